alu: RTL and testbench

- 8-bit (parameterisable) integer ALU for the core datapath. Computes add, subtract, AND, OR or XOR of two operands.
- The result is available combinationally on y.
- A registered copy of the result, status flags and an illegal-opcode indicator are captured on the clock edge for downstream sequencing logic.

---
 rtl/alu.sv | 125 ++++++++++++
 tb/tb_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// rtl/alu.sv - parameterisable integer ALU with combinational result and registered result/flags
//
// Purpose:
//   Computes ADD, SUB, AND, OR or XOR of two WIDTH-bit operands. The result
//   is driven combinationally on y. When in_valid is high, a clock edge
//   captures the result, its status flags and an illegal-opcode indicator
//   into a one-cycle registered stage.
//
// Ports:
//   clk        in   1      system clock, rising-edge active
//   rst        in   1      asynchronous active-high reset (registered stage only)
//   a, b       in   WIDTH  operands
//   op         in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101-111 reserved
//   in_valid   in   1      qualifies a/b/op for capture
//   y          out  WIDTH  combinational result
//   y_q        out  WIDTH  registered result
//   out_valid  out  1      registered stage holds an operation captured on the last edge
//   carry      out  1      registered carry-out (ADD) / borrow (SUB)
//   zero       out  1      registered y_q == 0
//   negative   out  1      registered MSB of y_q
//   overflow   out  1      registered signed overflow
//   illegal_op out  1      registered reserved-opcode indicator
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal_op
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  // One extra bit on each side: bit WIDTH of the sum is carry-out, and
  // bit WIDTH of the difference is the borrow (set exactly when a < b).
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             overflow_d;
  logic             illegal_d;

  logic             out_valid_q;
  logic             carry_q;
  logic             zero_q;
  logic             negative_q;
  logic             overflow_q;
  logic             illegal_q;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_d      = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    illegal_d  = 1'b0;
    case (op)
      OP_ADD: begin
        res_d      = sum_ext[MSB:0];
        carry_d    = sum_ext[WIDTH];
        // Same-sign operands producing a result of the other sign.
        overflow_d = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res_d      = diff_ext[MSB:0];
        carry_d    = diff_ext[WIDTH];
        // Opposite-sign operands whose result sign departs from a.
        overflow_d = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
      end
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      default: illegal_d = 1'b1;
    endcase
  end

  assign y = res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        y_q        <= res_d;
        carry_q    <= carry_d;
        zero_q     <= (res_d == '0);
        negative_q <= res_d[MSB];
        overflow_q <= overflow_d;
        illegal_q  <= illegal_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign carry      = carry_q;
  assign zero       = zero_q;
  assign negative   = negative_q;
  assign overflow   = overflow_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - table-driven self-checking bench for alu
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       in_valid;
  logic [7:0] y;
  logic [7:0] y_q;
  logic       out_valid;
  logic       carry;
  logic       zero;
  logic       negative;
  logic       overflow;
  logic       illegal_op;

  int checks;
  int failures;

  alu #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .op         (op),
    .in_valid   (in_valid),
    .y          (y),
    .y_q        (y_q),
    .out_valid  (out_valid),
    .carry      (carry),
    .zero       (zero),
    .negative   (negative),
    .overflow   (overflow),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Order: {out_valid, carry, zero, negative, overflow, illegal_op}
  function automatic logic [5:0] flags();
    return {out_valid, carry, zero, negative, overflow, illegal_op};
  endfunction

  task automatic add_vec(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] vy, input logic c, input logic z,
                         input logic n, input logic v, input logic ill);
    vec_t t;
    t.op = o; t.a = va; t.b = vb; t.y = vy;
    t.c = c; t.z = z; t.n = n; t.v = v; t.ill = ill;
    vecs.push_back(t);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //        op     a      b      y      c  z  n  v  ill
    add_vec(3'd0, 8'd10, 8'd5,  8'd15, 0, 0, 0, 0, 0);
    add_vec(3'd1, 8'd10, 8'd5,  8'd5,  0, 0, 0, 0, 0);
    add_vec(3'd2, 8'd10, 8'd5,  8'd0,  0, 1, 0, 0, 0);
    add_vec(3'd3, 8'd10, 8'd5,  8'd15, 0, 0, 0, 0, 0);
    add_vec(3'd4, 8'd10, 8'd5,  8'd15, 0, 0, 0, 0, 0);
    add_vec(3'd0, 8'd0,  8'd0,  8'd0,  0, 1, 0, 0, 0);
    add_vec(3'd0, 8'd0,  8'd5,  8'd5,  0, 0, 0, 0, 0);
    add_vec(3'd1, 8'd5,  8'd0,  8'd5,  0, 0, 0, 0, 0);
    add_vec(3'd2, 8'd0,  8'd0,  8'd0,  0, 1, 0, 0, 0);
    add_vec(3'd3, 8'd0,  8'd0,  8'd0,  0, 1, 0, 0, 0);
    add_vec(3'd4, 8'd0,  8'd0,  8'd0,  0, 1, 0, 0, 0);
    add_vec(3'd0, 8'hFF, 8'hFF, 8'hFE, 1, 0, 1, 0, 0);
    add_vec(3'd1, 8'hFF, 8'h00, 8'hFF, 0, 0, 1, 0, 0);
    add_vec(3'd2, 8'hFF, 8'hFF, 8'hFF, 0, 0, 1, 0, 0);
    add_vec(3'd3, 8'hFF, 8'hFF, 8'hFF, 0, 0, 1, 0, 0);
    add_vec(3'd4, 8'hFF, 8'hFF, 8'h00, 0, 1, 0, 0, 0);
    add_vec(3'd2, 8'hAA, 8'h55, 8'h00, 0, 1, 0, 0, 0);
    add_vec(3'd3, 8'hAA, 8'h55, 8'hFF, 0, 0, 1, 0, 0);
    add_vec(3'd4, 8'hAA, 8'h55, 8'hFF, 0, 0, 1, 0, 0);
    add_vec(3'd4, 8'hCC, 8'h33, 8'hFF, 0, 0, 1, 0, 0);
    add_vec(3'd0, 8'd1,  8'd1,  8'd2,  0, 0, 0, 0, 0);
    add_vec(3'd3, 8'h80, 8'h80, 8'h80, 0, 0, 1, 0, 0);
    add_vec(3'd4, 8'd1,  8'd0,  8'd1,  0, 0, 0, 0, 0);
    add_vec(3'd5, 8'd10, 8'd5,  8'd0,  0, 1, 0, 0, 1);
    add_vec(3'd6, 8'd10, 8'd5,  8'd0,  0, 1, 0, 0, 1);
    add_vec(3'd7, 8'd10, 8'd5,  8'd0,  0, 1, 0, 0, 1);
    add_vec(3'd0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0);
    add_vec(3'd1, 8'h00, 8'h01, 8'hFF, 1, 0, 1, 0, 0);
    add_vec(3'd1, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1, 0);
    add_vec(3'd0, 8'h80, 8'h80, 8'h00, 1, 1, 0, 1, 0);
    add_vec(3'd1, 8'h01, 8'h01, 8'h00, 0, 1, 0, 0, 0);

    // Reset state, before any clock edge.
    rst = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0; op = 3'd0;
    #1;
    check("reset_y_q", 32'(y_q), 32'h0);
    check("reset_flags", 32'(flags()), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: back-to-back captures, in_valid high every cycle.
    foreach (vecs[i]) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1'b1;
      #1;
      check($sformatf("y[%0d]", i), 32'(y), 32'(vecs[i].y));
      @(posedge clk);
      #1;
      check($sformatf("y_q[%0d]", i), 32'(y_q), 32'(vecs[i].y));
      check($sformatf("flags[%0d]", i), 32'(flags()),
            32'({1'b1, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].ill}));
    end

    // One-cycle latency: registered stage still holds 1-1=0 until the edge.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; op = 3'd0; in_valid = 1'b1;
    #1;
    check("latency_y_comb", 32'(y), 32'h80);
    check("latency_y_q_pre", 32'(y_q), 32'h00);
    @(posedge clk);
    #1;
    check("latency_y_q_post", 32'(y_q), 32'h80);
    check("latency_flags", 32'(flags()), 32'b100110);

    // in_valid low: out_valid drops, result and flags hold.
    @(negedge clk);
    a = 8'h00; b = 8'h01; op = 3'd1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hold_y_q", 32'(y_q), 32'h80);
    check("hold_flags", 32'(flags()), 32'b000110);
    check("hold_y_comb", 32'(y), 32'hFF);

    // Re-capture borrow case, then reset between edges.
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("borrow_flags", 32'(flags()), 32'b110100);
    #2;
    rst = 1'b1;
    a = 8'd10; b = 8'd5; op = 3'd4;
    #1;
    check("async_rst_y_q", 32'(y_q), 32'h0);
    check("async_rst_flags", 32'(flags()), 32'h0);
    check("async_rst_y_comb", 32'(y), 32'h0F);
    @(posedge clk);
    #1;
    check("rst_held_flags", 32'(flags()), 32'h0);

    // Recovery after reset release.
    @(negedge clk);
    rst = 1'b0; a = 8'hFF; b = 8'h01; op = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_y_q", 32'(y_q), 32'h00);
    check("post_rst_flags", 32'(flags()), 32'b111000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
